// File: rtl/jt12_pkg.sv
// Shared constants for the jt12 timer register slice.
//  - Part-I register addresses that control timers A and B.
//  - Bit positions of the fields inside the timer control register (0x27).
package jt12_pkg;

  localparam logic [7:0] REG_TIMA_HI = 8'h24;
  localparam logic [7:0] REG_TIMA_LO = 8'h25;
  localparam logic [7:0] REG_TIMB    = 8'h26;
  localparam logic [7:0] REG_TIMCTL  = 8'h27;

  localparam int unsigned CTL_LOAD_A = 0;
  localparam int unsigned CTL_LOAD_B = 1;
  localparam int unsigned CTL_IRQ_A  = 2;
  localparam int unsigned CTL_IRQ_B  = 3;
  localparam int unsigned CTL_CLR_A  = 4;
  localparam int unsigned CTL_CLR_B  = 5;
  localparam int unsigned CTL_CH3_LO = 6;
  localparam int unsigned CTL_CH3_HI = 7;

endpackage

// File: rtl/jt12_busy_cnt.sv
// Write-busy counter.
//  clk_i, rst_i : clock, synchronous active-high reset
//  cen_i        : clock enable, gates the countdown only
//  load_i       : reload the counter with BUSY_CNT (wins over countdown)
//  busy_o       : high while the counter is non-zero
module jt12_busy_cnt #(
  parameter int unsigned BUSY_CNT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cen_i,
  input  logic load_i,
  output logic busy_o
);

  localparam int unsigned W = $clog2(BUSY_CNT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = W'(BUSY_CNT);
    else if (cen_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/jt12_timer_regs.sv
// CPU-side writer for the FM timer block (YM2612 part-I regs 0x24-0x27).
//  clk, rst       : clock, synchronous active-high reset
//  cen            : clock enable for the busy countdown
//  cs_n, wr_n     : active-low chip select / write strobe (level)
//  addr[1:0]      : [0]=0 address cycle, 1 data cycle; [1]=part select
//  din            : CPU write data
//  flag_A/B       : timer flags from jt12_timers
//  dout           : registered status {busy,5'b0,flag_B,flag_A}
//  value_A/B      : timer start values
//  load_*, enable_irq_*, ch3_mode : levels from reg 0x27
//  clr_flag_*     : one-clk pulses from reg 0x27 bits 4/5
//  busy           : write-busy flag
module jt12_timer_regs #(
  parameter int unsigned BUSY_CNT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] dout,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [1:0] ch3_mode,
  output logic       busy
);

  import jt12_pkg::*;

  logic       we, we_q, wr_stb, addr_cyc, data_cyc, part_one;
  logic [7:0] sel_q;
  logic       sel_part_q;
  logic [7:0] dout_q, value_B_q;
  logic [9:0] value_A_q;
  logic [1:0] ch3_q;
  logic       load_A_q, load_B_q, irq_A_q, irq_B_q, clr_A_q, clr_B_q;

  // we_q resets to 1 so a strobe already asserted when reset releases is not a write.
  assign we       = ~cs_n & ~wr_n;
  assign wr_stb   = we & ~we_q;
  assign addr_cyc = wr_stb & ~addr[0];
  assign data_cyc = wr_stb &  addr[0];
  assign part_one = ~sel_part_q & ~addr[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b1;
      sel_q      <= '0;
      sel_part_q <= 1'b0;
      dout_q     <= '0;
      value_A_q  <= '0;
      value_B_q  <= '0;
      ch3_q      <= '0;
      load_A_q   <= 1'b0;
      load_B_q   <= 1'b0;
      irq_A_q    <= 1'b0;
      irq_B_q    <= 1'b0;
      clr_A_q    <= 1'b0;
      clr_B_q    <= 1'b0;
    end else begin
      we_q    <= we;
      dout_q  <= {busy, 5'b0, flag_B, flag_A};
      clr_A_q <= 1'b0;
      clr_B_q <= 1'b0;
      if (addr_cyc) begin
        sel_q      <= din;
        sel_part_q <= addr[1];
      end
      if (data_cyc && part_one) begin
        case (sel_q)
          REG_TIMA_HI: value_A_q[9:2] <= din;
          REG_TIMA_LO: value_A_q[1:0] <= din[1:0];
          REG_TIMB:    value_B_q      <= din;
          REG_TIMCTL: begin
            load_A_q <= din[CTL_LOAD_A];
            load_B_q <= din[CTL_LOAD_B];
            irq_A_q  <= din[CTL_IRQ_A];
            irq_B_q  <= din[CTL_IRQ_B];
            clr_A_q  <= din[CTL_CLR_A];
            clr_B_q  <= din[CTL_CLR_B];
            ch3_q    <= din[CTL_CH3_HI:CTL_CH3_LO];
          end
          default: ;
        endcase
      end
    end
  end

  // Every data cycle restarts busy, whichever part or register it targets.
  jt12_busy_cnt #(.BUSY_CNT(BUSY_CNT)) u_busy (
    .clk_i  (clk),
    .rst_i  (rst),
    .cen_i  (cen),
    .load_i (data_cyc),
    .busy_o (busy)
  );

  assign dout         = dout_q;
  assign value_A      = value_A_q;
  assign value_B      = value_B_q;
  assign load_A       = load_A_q;
  assign load_B       = load_B_q;
  assign enable_irq_A = irq_A_q;
  assign enable_irq_B = irq_B_q;
  assign clr_flag_A   = clr_A_q;
  assign clr_flag_B   = clr_B_q;
  assign ch3_mode     = ch3_q;

endmodule

// File: tb/tb_jt12_timer_regs.sv
module tb_jt12_timer_regs;

  localparam int BUSY = 32;
  localparam int NCYC = 16384;

  logic       clk = 1'b0;
  logic       rst, cen, cs_n, wr_n, flag_A, flag_B;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout, value_B;
  logic [9:0] value_A;
  logic       load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, busy;
  logic [1:0] ch3_mode;

  jt12_timer_regs #(.BUSY_CNT(BUSY)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .flag_A(flag_A), .flag_B(flag_B), .dout(dout), .value_A(value_A), .value_B(value_B),
    .load_A(load_A), .load_B(load_B), .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .ch3_mode(ch3_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [34:0] v; } item_t;
  item_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit cen_arr [0:NCYC-1];

  // Reference model: register file indexed by address, busy as "cen ticks since last data write".
  logic [7:0] regs [0:255];
  logic [7:0] m_sel;
  logic       m_part, m_prev_we, m_clrA, m_clrB, m_busy;
  logic [7:0] m_dout;
  int         m_last_dw;

  function automatic int remaining();
    int c = 0;
    if (m_last_dw < 0) return 0;
    for (int j = m_last_dw + 1; j <= cyc && c < BUSY; j++) c += int'(cen_arr[j]);
    return (c >= BUSY) ? 0 : BUSY - c;
  endfunction

  // Applies the inputs held across edge number cyc to the model and queues the expectation.
  task automatic model_edge();
    item_t it;
    logic  we, wr;
    logic [9:0] va;
    if (rst) begin
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      m_sel = 8'h00; m_part = 1'b0; m_prev_we = 1'b1; m_clrA = 1'b0; m_clrB = 1'b0;
      m_last_dw = -1; m_busy = 1'b0; m_dout = 8'h00;
    end else begin
      we = !cs_n && !wr_n;
      wr = we && !m_prev_we;
      m_prev_we = we;
      m_clrA = 1'b0; m_clrB = 1'b0;
      m_dout = {m_busy, 5'b0, flag_B, flag_A};
      if (wr && !addr[0]) begin
        m_sel = din; m_part = addr[1];
      end else if (wr) begin
        m_last_dw = cyc;
        if (!m_part && !addr[1] && m_sel >= 8'h24 && m_sel <= 8'h27) begin
          regs[m_sel] = din;
          if (m_sel == 8'h27) begin m_clrA = din[4]; m_clrB = din[5]; end
        end
      end
      m_busy = (remaining() > 0);
    end
    va = {regs[8'h24], regs[8'h25][1:0]};
    it.cyc = cyc;
    it.v = {m_dout, va, regs[8'h26], regs[8'h27][0], regs[8'h27][1], regs[8'h27][2],
            regs[8'h27][3], m_clrA, m_clrB, regs[8'h27][7:6], m_busy};
    sb.push_back(it);
  endtask

  task automatic step();
    cen = cen_arr[cyc + 1];
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    repeat (hold) step();
    cs_n = 1'b1; wr_n = 1'b1;
    step();
  endtask

  // Monitor: pops every expectation due at this cycle and compares against the DUT.
  item_t       mon_it;
  logic [34:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_it = sb.pop_front();
      n_vec++;
      act = {dout, value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
             clr_flag_A, clr_flag_B, ch3_mode, busy};
      if (mon_it.cyc != cyc || act !== mon_it.v) begin
        n_err++;
        $display("FAIL outputs@cyc%0d (dout,vA,vB,ldA,ldB,irqA,irqB,clrA,clrB,ch3,busy) got=%h exp=%h",
                 mon_it.cyc, act, mon_it.v);
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < NCYC; i++) cen_arr[i] = ($urandom_range(0, 3) != 0);
    rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 2'd0; din = 8'h00;
    flag_A = 1'b0; flag_B = 1'b0; cen = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Timer A value through both bytes
    wr(2'd0, 8'h24, 1); wr(2'd1, 8'hAB, 1);
    wr(2'd0, 8'h25, 1); wr(2'd1, 8'h03, 1);
    repeat (80) step();

    // Control register with both clear pulses
    wr(2'd0, 8'h27, 1); wr(2'd1, 8'h3F, 1);
    repeat (4) step();

    // Held strobe produces one write
    wr(2'd0, 8'h26, 1); wr(2'd1, 8'h80, 10);
    repeat (4) step();

    // Part II selection is ignored but still starts busy
    wr(2'd2, 8'h26, 1); wr(2'd3, 8'h55, 1);
    k = 0;
    while (remaining() != 5 && k < 200) begin step(); k++; end
    n_vec++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL busy_countdown_to_5 got=timeout exp=remaining 5");
    end
    wr(2'd1, 8'h11, 1);
    flag_A = 1'b1; flag_B = 1'b1;
    repeat (5) step();
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (3) step();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [1:0] a;
      logic [7:0] d;
      a = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if (!a[0] && $urandom_range(0, 7) != 0) d = 8'h24 + 8'($urandom_range(0, 3));
      else                                    d = 8'($urandom);
      flag_A = 1'($urandom); flag_B = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      wr(a, d, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (40) step();

    @(negedge clk); #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
